// File: rtl/spi_shift_engine_pkg.sv
// Shared SPI defines: character/divider sizes, shift-state
// encoding, capture bundle and bit-position helpers.
package spi_shift_engine_pkg;

    localparam int SPI_DIVIDER_LEN   = 16;
    localparam int SPI_MAX_CHAR      = 32;
    localparam int SPI_CHAR_LEN_BITS = 5;
    localparam int SPI_CNT_W         = SPI_CHAR_LEN_BITS + 1;

    typedef logic [SPI_MAX_CHAR-1:0] spi_char_t;
    typedef logic [SPI_CNT_W-1:0]    spi_cnt_t;

    typedef enum logic [1:0] {
        SH_IDLE  = 2'd0,
        SH_SHIFT = 2'd1,
        SH_DRAIN = 2'd2
    } spi_shift_state_e;

    // Transfer framing captured at start.
    typedef struct packed {
        spi_cnt_t len;
        logic     lsb;
        logic     tx_negedge;
        logic     rx_negedge;
    } spi_cfg_t;

    function automatic spi_cnt_t spi_len_eff(
        input logic [SPI_CHAR_LEN_BITS-1:0] len
    );
        spi_cnt_t r;
        if (len == '0)
            r = spi_cnt_t'(SPI_MAX_CHAR);
        else
            r = {1'b0, len};
        return r;
    endfunction

    function automatic logic [SPI_CHAR_LEN_BITS-1:0] spi_top_idx(
        input spi_cnt_t n
    );
        return SPI_CHAR_LEN_BITS'(n - spi_cnt_t'(1));
    endfunction

    function automatic logic spi_tx_bit(
        input spi_char_t d,
        input spi_cnt_t  n,
        input logic      lsb
    );
        logic r;
        if (lsb)
            r = d[0];
        else
            r = d[spi_top_idx(n)];
        return r;
    endfunction

    function automatic spi_char_t spi_shift_in(
        input spi_char_t d,
        input spi_cnt_t  n,
        input logic      lsb,
        input logic      din
    );
        spi_char_t r;
        if (lsb) begin
            r = d >> 1;
            r[spi_top_idx(n)] = din;
        end else begin
            r = {d[SPI_MAX_CHAR-2:0], din};
        end
        return r;
    endfunction

    function automatic spi_char_t spi_len_mask(input spi_cnt_t n);
        spi_char_t m;
        for (int i = 0; i < SPI_MAX_CHAR; i++)
            m[i] = (i < int'(n));
        return m;
    endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Host-side bus of the shift engine: start/load control,
// framing setup, TX write data and RX read data.
interface spi_shift_engine_if;
    import spi_shift_engine_pkg::*;

    logic                         go;
    logic [SPI_CHAR_LEN_BITS-1:0] len;
    logic                         lsb;
    logic                         tx_negedge;
    logic                         rx_negedge;
    logic                         load;
    spi_char_t                    wr_data;
    spi_char_t                    rx_data;

    modport master (
        output go, len, lsb, tx_negedge, rx_negedge,
        output load, wr_data,
        input  rx_data
    );

    modport slave (
        input  go, len, lsb, tx_negedge, rx_negedge,
        input  load, wr_data,
        output rx_data
    );

endinterface

// File: rtl/spi_shift_engine_edge_sel.sv
// spi_edge_sel: picks the TX and RX shift strobes from the
// SCLK generator strobes, gated by tip.
// Ports: tip, pos_edge, neg_edge, tx_negedge, rx_negedge in;
// tx_clk, rx_clk out.
module spi_edge_sel (
    input  logic tip,
    input  logic pos_edge,
    input  logic neg_edge,
    input  logic tx_negedge,
    input  logic rx_negedge,
    output logic tx_clk,
    output logic rx_clk
);

    assign tx_clk = tip & (tx_negedge ? neg_edge : pos_edge);
    assign rx_clk = tip & (rx_negedge ? neg_edge : pos_edge);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master character shift engine (CPOL=0), 1..32 bits.
// Ports: wb_clk_in, wb_rst (async, active-high); bus (host
// slave modport); pos_edge, neg_edge, miso from the line/
// generator; tip, last_clk, mosi out; done out only when
// SPI_SHIFT_DONE_EN is defined.
module spi_shift_engine
    import spi_shift_engine_pkg::*;
(
    input  logic              wb_clk_in,
    input  logic              wb_rst,
    spi_shift_engine_if.slave bus,
    input  logic              pos_edge,
    input  logic              neg_edge,
    input  logic              miso,
    output logic              tip,
    output logic              last_clk,
    output logic              mosi
`ifdef SPI_SHIFT_DONE_EN
    ,
    output logic              done
`endif
);

    spi_shift_state_e state_q, state_d;
    spi_cnt_t         cnt_q, cnt_d;
    spi_char_t        data_q, data_d;
    spi_cfg_t         cfg_q, cfg_d;
    logic             mosi_q, mosi_d;
    logic             sampled_q, sampled_d;

    logic tx_clk;
    logic rx_clk;
    logic end_stb;
    logic tx_fire;

    spi_edge_sel u_edge_sel (
        .tip        (tip),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .tx_negedge (cfg_q.tx_negedge),
        .rx_negedge (cfg_q.rx_negedge),
        .tx_clk     (tx_clk),
        .rx_clk     (rx_clk)
    );

    assign tip      = (state_q != SH_IDLE);
    assign last_clk = (state_q == SH_DRAIN);
    assign mosi     = mosi_q;

    assign bus.rx_data = data_q & spi_len_mask(cfg_q.len);

    // With rx on the falling edge the last sample and the
    // final falling SCLK are the same strobe.
    assign end_stb = tip && neg_edge &&
        ((cnt_q == '0) ||
         ((cnt_q == spi_cnt_t'(1)) && cfg_q.rx_negedge));

    // Next bit goes out only after the current one was
    // sampled, and only if another bit remains.
    assign tx_fire = tx_clk &&
        (rx_clk ? (cnt_q > spi_cnt_t'(1))
                : (sampled_q && (cnt_q != '0)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        cfg_d     = cfg_q;
        mosi_d    = mosi_q;
        sampled_d = sampled_q;

        unique case (state_q)
            SH_IDLE: begin
                if (bus.load)
                    data_d = bus.wr_data;
                if (bus.go) begin
                    cfg_d.len        = spi_len_eff(bus.len);
                    cfg_d.lsb        = bus.lsb;
                    cfg_d.tx_negedge = bus.tx_negedge;
                    cfg_d.rx_negedge = bus.rx_negedge;
                    cnt_d     = cfg_d.len;
                    mosi_d    = spi_tx_bit(data_d, cfg_d.len,
                                           bus.lsb);
                    sampled_d = 1'b0;
                    state_d   = SH_SHIFT;
                end
            end
            SH_SHIFT: begin
                if (rx_clk) begin
                    data_d    = spi_shift_in(data_q, cfg_q.len,
                                             cfg_q.lsb, miso);
                    cnt_d     = cnt_q - spi_cnt_t'(1);
                    sampled_d = 1'b1;
                end
                if (tx_fire) begin
                    mosi_d    = spi_tx_bit(data_d, cfg_q.len,
                                           cfg_q.lsb);
                    sampled_d = 1'b0;
                end
                if (end_stb)
                    state_d = SH_IDLE;
                else if (cnt_d == '0)
                    state_d = SH_DRAIN;
            end
            SH_DRAIN: begin
                if (end_stb)
                    state_d = SH_IDLE;
            end
            default: state_d = SH_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            state_q   <= SH_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            cfg_q     <= '{len: spi_cnt_t'(SPI_MAX_CHAR),
                           lsb: 1'b0,
                           tx_negedge: 1'b0,
                           rx_negedge: 1'b0};
            mosi_q    <= 1'b0;
            sampled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            cfg_q     <= cfg_d;
            mosi_q    <= mosi_d;
            sampled_q <= sampled_d;
        end
    end

`ifdef SPI_SHIFT_DONE_EN
    logic done_q, done_d;

    assign done_d = (state_q != SH_IDLE) &&
                    (state_d == SH_IDLE);
    assign done   = done_q;

    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst)
            done_q <= 1'b0;
        else
            done_q <= done_d;
    end
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine with a small
// divider-1 SCLK generator model driving the edge strobes.
module tb_spi_shift_engine;
    import spi_shift_engine_pkg::*;

    localparam int DIV = 1;

    logic clk;
    logic rst;
    logic pos_edge, neg_edge, miso;
    logic tip, last_clk, mosi;
    logic lp, mi;
    logic sclk;
    int   div_cnt;
`ifdef SPI_SHIFT_DONE_EN
    logic done;
`endif

    int n_chk;
    int n_fail;

    spi_shift_engine_if bus ();

    spi_shift_engine dut (
        .wb_clk_in (clk),
        .wb_rst    (rst),
        .bus       (bus),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .miso      (miso),
        .tip       (tip),
        .last_clk  (last_clk),
        .mosi      (mosi)
`ifdef SPI_SHIFT_DONE_EN
        ,
        .done      (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign miso = lp ? mosi : mi;

    assign pos_edge = tip && !sclk && !last_clk &&
                      (div_cnt == DIV);
    assign neg_edge = tip && sclk && (div_cnt == DIV);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk    <= 1'b0;
            div_cnt <= 0;
        end else if (!tip) begin
            sclk    <= 1'b0;
            div_cnt <= 0;
        end else begin
            div_cnt <= (div_cnt == DIV) ? 0 : div_cnt + 1;
            if (pos_edge)
                sclk <= 1'b1;
            else if (neg_edge)
                sclk <= 1'b0;
        end
    end

    typedef struct {
        logic [31:0] d;
        logic [4:0]  len;
        logic        lsb, tn, rn, lp, mi;
        logic [31:0] rx, seq;
        int          nb, tc, lc;
        logic        m0;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic start_xfer(input logic [31:0] d,
                              input logic [4:0] l,
                              input logic ls, tn, rn);
        @(negedge clk);
        bus.wr_data    = d;
        bus.load       = 1'b1;
        bus.go         = 1'b1;
        bus.len        = l;
        bus.lsb        = ls;
        bus.tx_negedge = tn;
        bus.rx_negedge = rn;
        @(negedge clk);
        bus.load       = 1'b0;
        bus.go         = 1'b0;
        bus.len        = ~l;
        bus.lsb        = ~ls;
        bus.tx_negedge = ~tn;
        bus.rx_negedge = ~rn;
    endtask

    task automatic run_xfer(input logic rn, input int inj,
                            output int tc, output int lc,
                            output int nb,
                            output logic [31:0] seq,
                            output logic m0);
        int g;
        int dn;
        tc = 0; lc = 0; nb = 0; seq = '0; g = 0; dn = 0;
        m0 = mosi;
        while (tip && g < 400) begin
            if (inj >= 0 && g == inj) begin
                bus.go      = 1'b1;
                bus.load    = 1'b1;
                bus.wr_data = 32'hFFFF_FFFF;
            end else begin
                bus.go   = 1'b0;
                bus.load = 1'b0;
            end
            tc++;
            if (last_clk) lc++;
            if (rn ? neg_edge : pos_edge) begin
                nb++;
                seq = {seq[30:0], mosi};
            end
`ifdef SPI_SHIFT_DONE_EN
            if (done) dn++;
`endif
            @(negedge clk);
            g++;
        end
        bus.go   = 1'b0;
        bus.load = 1'b0;
        chk("xfer_ends", {31'd0, tip}, 32'd0);
`ifdef SPI_SHIFT_DONE_EN
        chk("done_during_tip", dn, 0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("done_clears", {31'd0, done}, 32'd0);
`endif
    endtask

    initial begin
        int tc, lc, nb, k;
        logic [31:0] seq;
        logic m0;

        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        lp = 1'b0;
        mi = 1'b0;
        bus.go = 1'b0;
        bus.load = 1'b0;
        bus.len = '0;
        bus.lsb = 1'b0;
        bus.tx_negedge = 1'b0;
        bus.rx_negedge = 1'b0;
        bus.wr_data = '0;

        vt[0] = '{32'h0000_00A5, 5'd8,  0, 1, 0, 1, 0,
                  32'h0000_00A5, 32'h0000_00A5, 8, 32, 2, 1};
        vt[1] = '{32'h8000_0001, 5'd0,  1, 1, 0, 0, 0,
                  32'h0000_0000, 32'h8000_0001, 32, 128, 2, 1};
        vt[2] = '{32'h0000_0005, 5'd3,  0, 0, 1, 0, 1,
                  32'h0000_0007, 32'h0000_0005, 3, 12, 0, 1};
        vt[3] = '{32'h1234_5678, 5'd16, 1, 1, 0, 1, 0,
                  32'h0000_5678, 32'h0000_1E6A, 16, 64, 2, 0};
        vt[4] = '{32'h0000_0001, 5'd1,  0, 1, 0, 0, 0,
                  32'h0000_0000, 32'h0000_0001, 1, 4, 2, 1};
        vt[5] = '{32'h0000_0000, 5'd1,  0, 0, 1, 0, 1,
                  32'h0000_0001, 32'h0000_0000, 1, 4, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_tip", {31'd0, tip}, 32'd0);
        chk("rst_last_clk", {31'd0, last_clk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_rx_data", bus.rx_data, 32'd0);
`ifdef SPI_SHIFT_DONE_EN
        chk("rst_done", {31'd0, done}, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            lp = vt[i].lp;
            mi = vt[i].mi;
            start_xfer(vt[i].d, vt[i].len, vt[i].lsb,
                       vt[i].tn, vt[i].rn);
            run_xfer(vt[i].rn, -1, tc, lc, nb, seq, m0);
            chk($sformatf("v%0d_rx_data", i),
                bus.rx_data, vt[i].rx);
            chk($sformatf("v%0d_mosi_seq", i), seq, vt[i].seq);
            chk($sformatf("v%0d_bits", i), nb, vt[i].nb);
            chk($sformatf("v%0d_tip_cycles", i), tc, vt[i].tc);
            chk($sformatf("v%0d_last_clk_cycles", i),
                lc, vt[i].lc);
            chk($sformatf("v%0d_first_mosi", i),
                {31'd0, m0}, {31'd0, vt[i].m0});
            chk($sformatf("v%0d_sclk_low", i),
                {31'd0, sclk}, 32'd0);
            repeat (2) @(negedge clk);
        end

        // go + load mid-transfer are ignored
        lp = 1'b1;
        start_xfer(32'h0000_003C, 5'd8, 1'b0, 1'b1, 1'b0);
        run_xfer(1'b0, 10, tc, lc, nb, seq, m0);
        chk("ign_rx_data", bus.rx_data, 32'h0000_003C);
        chk("ign_tip_cycles", tc, 32);
        chk("ign_mosi_seq", seq, 32'h0000_003C);
        repeat (5) @(negedge clk);
        chk("ign_no_restart", {31'd0, tip}, 32'd0);
        chk("ign_rx_hold", bus.rx_data, 32'h0000_003C);

        // async reset at bit 4 of 8, then clean restart
        start_xfer(32'h0000_00FF, 5'd8, 1'b0, 1'b1, 1'b0);
        k = 0;
        for (int g = 0; g < 100 && k < 4; g++) begin
            if (pos_edge) k++;
            @(negedge clk);
        end
        chk("rst_mid_reached", k, 4);
        #1 rst = 1'b1;
        #1;
        chk("abort_tip", {31'd0, tip}, 32'd0);
        chk("abort_last_clk", {31'd0, last_clk}, 32'd0);
        chk("abort_mosi", {31'd0, mosi}, 32'd0);
        chk("abort_rx_data", bus.rx_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_xfer(32'h0000_0096, 5'd8, 1'b0, 1'b1, 1'b0);
        run_xfer(1'b0, -1, tc, lc, nb, seq, m0);
        chk("restart_rx_data", bus.rx_data, 32'h0000_0096);
        chk("restart_mosi_seq", seq, 32'h0000_0096);
        chk("restart_tip_cycles", tc, 32);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
